// File: rtl/state_sequencer.sv
// Control-state sequencer for the multi-cycle MIPS32 core: next-state decode,
// illegal-instruction pulse and retired-instruction counter.
module state_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  output logic [4:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [4:0] s0  = 5'd0;
  localparam logic [4:0] s1  = 5'd1;
  localparam logic [4:0] s2  = 5'd2;
  localparam logic [4:0] s3  = 5'd3;
  localparam logic [4:0] s4  = 5'd4;
  localparam logic [4:0] s5  = 5'd5;
  localparam logic [4:0] s6  = 5'd6;
  localparam logic [4:0] s7  = 5'd7;
  localparam logic [4:0] s8  = 5'd8;
  localparam logic [4:0] s9  = 5'd9;
  localparam logic [4:0] s10 = 5'd10;
  localparam logic [4:0] s11 = 5'd11;
  localparam logic [4:0] s12 = 5'd12;
  localparam logic [4:0] s13 = 5'd13;
  localparam logic [4:0] s14 = 5'd14;
  localparam logic [4:0] s15 = 5'd15;
  localparam logic [4:0] s16 = 5'd16;
  localparam logic [4:0] s17 = 5'd17;
  localparam logic [4:0] s18 = 5'd18;
  localparam logic [4:0] s19 = 5'd19;
  localparam logic [4:0] s21 = 5'd21;

  localparam logic [5:0] op_r     = 6'b000000;
  localparam logic [5:0] op_lw    = 6'b100011;
  localparam logic [5:0] op_sw    = 6'b101011;
  localparam logic [5:0] op_lb    = 6'b100000;
  localparam logic [5:0] op_sb    = 6'b101000;
  localparam logic [5:0] op_beq   = 6'b000100;
  localparam logic [5:0] op_j     = 6'b000010;
  localparam logic [5:0] op_jal   = 6'b000011;
  localparam logic [5:0] op_ori   = 6'b001101;
  localparam logic [5:0] op_lui   = 6'b001111;
  localparam logic [5:0] op_addi  = 6'b001000;
  localparam logic [5:0] op_addiu = 6'b001001;

  localparam logic [5:0] fn_addu = 6'b100001;
  localparam logic [5:0] fn_subu = 6'b100011;
  localparam logic [5:0] fn_slt  = 6'b101010;
  localparam logic [5:0] fn_jr   = 6'b001000;

  // Final state of every legal instruction path.
  localparam logic [31:0] term_mask =
      (32'd1 << s4)  | (32'd1 << s5)  | (32'd1 << s7)  | (32'd1 << s8)  |
      (32'd1 << s9)  | (32'd1 << s12) | (32'd1 << s15) | (32'd1 << s17) |
      (32'd1 << s18);

  logic [4:0]       state_reg, state_next;
  logic             illegal_reg, illegal_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      state_hot;
  logic             is_term;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_hot
      assign state_hot[gi] = (state_reg == 5'(gi));
    end
  endgenerate

  assign is_term = |(state_hot & term_mask);

  always_comb begin
    state_next   = s0;
    illegal_next = 1'b0;
    case (state_reg)
      s0: state_next = s1;
      s1: begin
        case (op)
          op_r: begin
            case (funct)
              fn_addu: state_next = s6;
              fn_subu: state_next = s10;
              fn_slt:  state_next = s11;
              fn_jr:   state_next = s12;
              default: illegal_next = 1'b1;
            endcase
          end
          op_lw, op_sw, op_sb: state_next = s2;
          op_lb:    state_next = s16;
          op_beq:   state_next = s8;
          op_j:     state_next = s15;
          op_jal:   state_next = s9;
          op_ori:   state_next = s13;
          op_lui:   state_next = s14;
          op_addi:  state_next = s19;
          op_addiu: state_next = s21;
          default:  illegal_next = 1'b1;
        endcase
      end
      s2: begin
        case (op)
          op_lw:   state_next = s3;
          op_sw:   state_next = s5;
          op_sb:   state_next = s17;
          default: illegal_next = 1'b1;
        endcase
      end
      s3, s16:            state_next = s4;
      s6, s10, s11:       state_next = s7;
      s13, s14, s19, s21: state_next = s18;
      // Terminal states, s20 and unused codes all return to fetch.
      default:            state_next = s0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= s0;
      illegal_reg <= 1'b0;
      cnt_reg     <= '0;
    end else if (en) begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      if (is_term) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign state     = state_reg;
  assign illegal   = illegal_reg;
  assign instr_cnt = cnt_reg;
  assign retire    = en & is_term;

endmodule

// File: tb/tb_state_sequencer.sv
// Self-checking bench for state_sequencer: instruction table, hand-written
// corner sequences and randomized instructions/stalls against a path model.
module tb_state_sequencer;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_LB = 6'b100000, OP_SB = 6'b101000, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;
  localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_SLT = 6'b101010;
  localparam logic [5:0] F_JR = 6'b001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [5:0]  op = '0;
  logic [5:0]  funct = '0;
  logic [4:0]  state, state4;
  logic        retire, retire4, illegal, illegal4;
  logic [31:0] instr_cnt;
  logic [3:0]  instr_cnt4;

  always #5 clk = ~clk;

  state_sequencer #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .funct(funct),
    .state(state), .retire(retire), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  state_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .funct(funct),
    .state(state4), .retire(retire4), .illegal(illegal4), .instr_cnt(instr_cnt4)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cnt_model = 0;
  bit          ill_model = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the whole state path an instruction walks, fetch first.
  typedef struct packed {
    logic [4:0][4:0] s;
    logic [2:0]      n;
    logic            ill;
  } path_t;

  function automatic path_t mk(input int a, input int b, input int c);
    path_t p;
    p = '0;
    p.s[0] = 5'd0;
    p.s[1] = 5'd1;
    p.n    = 3'd2;
    p.ill  = (a < 0);
    if (a >= 0) begin p.s[2] = 5'(a); p.n = 3'd3; end
    if (b >= 0) begin p.s[3] = 5'(b); p.n = 3'd4; end
    if (c >= 0) begin p.s[4] = 5'(c); p.n = 3'd5; end
    return p;
  endfunction

  function automatic path_t path_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_LW:    return mk(2, 3, 4);
      OP_SW:    return mk(2, 5, -1);
      OP_SB:    return mk(2, 17, -1);
      OP_LB:    return mk(16, 4, -1);
      OP_BEQ:   return mk(8, -1, -1);
      OP_J:     return mk(15, -1, -1);
      OP_JAL:   return mk(9, -1, -1);
      OP_ORI:   return mk(13, 18, -1);
      OP_LUI:   return mk(14, 18, -1);
      OP_ADDI:  return mk(19, 18, -1);
      OP_ADDIU: return mk(21, 18, -1);
      OP_R: begin
        case (f)
          F_ADDU:  return mk(6, 7, -1);
          F_SUBU:  return mk(10, 7, -1);
          F_SLT:   return mk(11, 7, -1);
          F_JR:    return mk(12, -1, -1);
          default: return mk(-1, -1, -1);
        endcase
      end
      default: return mk(-1, -1, -1);
    endcase
  endfunction

  // Called at a falling edge with the DUT in s0; returns at a falling edge back in s0.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int stall_pct,
                           input int stall_idx, input int stall_len,
                           output int elapsed, output logic [4:0] last_state);
    path_t p;
    int    idx = 0;
    int    stalled = 0;
    bit    done = 1'b0;
    bit    e;
    bit    fin;
    p = path_of(o, f);
    op = o;
    funct = f;
    elapsed = 0;
    last_state = '0;
    while (!done && elapsed < 1000) begin
      e = 1'b1;
      if (idx == stall_idx && stalled < stall_len) begin
        e = 1'b0;
        stalled++;
      end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        e = 1'b0;
      end
      en = e;
      fin = (idx == int'(p.n) - 1);
      #1;
      check("state", state, p.s[idx]);
      check("retire", retire, e && !p.ill && fin);
      check("illegal", illegal, ill_model);
      check("instr_cnt", instr_cnt, cnt_model);
      check("instr_cnt4", instr_cnt4, cnt_model % 16);
      last_state = state;
      @(posedge clk);
      elapsed++;
      if (e) begin
        ill_model = p.ill && fin;
        if (!p.ill && fin) cnt_model++;
        if (fin) done = 1'b1;
        else idx++;
      end
      @(negedge clk);
    end
    if (!done) check("instr_timeout", 1, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    en = 1'b1;
    op = OP_LW;
    funct = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_state", state, 0);
      check("rst_cnt", instr_cnt, 0);
      check("rst_illegal", illegal, 0);
      check("rst_retire", retire, 0);
    end
    cnt_model = 0;
    ill_model = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    int         cycles;
    logic [4:0] last;
  } vec_t;

  vec_t       tbl[14];
  int         el;
  logic [4:0] ls;
  int unsigned cnt_before;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{OP_SW,    6'd0,   4, 5'd5};
    tbl[1]  = '{OP_R,     F_ADDU, 4, 5'd7};
    tbl[2]  = '{OP_R,     F_SUBU, 4, 5'd7};
    tbl[3]  = '{OP_R,     F_SLT,  4, 5'd7};
    tbl[4]  = '{OP_R,     F_JR,   3, 5'd12};
    tbl[5]  = '{OP_BEQ,   6'd0,   3, 5'd8};
    tbl[6]  = '{OP_J,     6'd0,   3, 5'd15};
    tbl[7]  = '{OP_JAL,   6'd0,   3, 5'd9};
    tbl[8]  = '{OP_ORI,   6'd0,   4, 5'd18};
    tbl[9]  = '{OP_LUI,   6'd0,   4, 5'd18};
    tbl[10] = '{OP_ADDI,  6'd0,   4, 5'd18};
    tbl[11] = '{OP_ADDIU, 6'd0,   4, 5'd18};
    tbl[12] = '{OP_LB,    6'd0,   4, 5'd4};
    tbl[13] = '{OP_SB,    6'd0,   4, 5'd17};

    @(negedge clk);
    apply_reset();
    run_instr(OP_LW, 6'd0, 0, -1, 0, el, ls);
    check("lw_cycles", el, 5);
    check("lw_last", ls, 4);
    check("lw_cnt", instr_cnt, 1);

    apply_reset();
    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].op, tbl[i].funct, 0, -1, 0, el, ls);
      $display("mix %0d op=%b funct=%b cycles=%0d last=s%0d", i, tbl[i].op, tbl[i].funct, el, ls);
      check("mix_cycles", el, tbl[i].cycles);
      check("mix_last", ls, tbl[i].last);
    end
    check("mix_cnt", instr_cnt, 14);

    cnt_before = cnt_model;
    run_instr(6'b111111, 6'd0, 0, -1, 0, el, ls);
    check("ill_op_cycles", el, 2);
    run_instr(OP_R, 6'b000000, 0, -1, 0, el, ls);
    check("ill_fn_cycles", el, 2);
    run_instr(OP_J, 6'd0, 0, -1, 0, el, ls);
    check("ill_cnt", instr_cnt, cnt_before + 1);

    run_instr(OP_LW, 6'd0, 0, 3, 4, el, ls);
    $display("stall lw elapsed=%0d", el);
    check("stall_elapsed", el, 9);

    // op changed to a non-memory opcode while in s2
    op = OP_LW;
    en = 1'b1;
    @(posedge clk); @(negedge clk);
    check("s2ill_s1", state, 1);
    @(posedge clk); @(negedge clk);
    check("s2ill_s2", state, 2);
    op = OP_BEQ;
    @(posedge clk); @(negedge clk);
    check("s2ill_state", state, 0);
    check("s2ill_pulse", illegal, 1);
    check("s2ill_cnt", instr_cnt, cnt_model);
    ill_model = 1'b1;
    run_instr(OP_J, 6'd0, 0, -1, 0, el, ls);

    apply_reset();
    op = OP_LW;
    en = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("midrst_s3", state, 3);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_state", state, 0);
    check("midrst_cnt", instr_cnt, 0);
    check("midrst_illegal", illegal, 0);
    rst_n = 1'b1;
    run_instr(OP_R, F_ADDU, 0, -1, 0, el, ls);
    check("midrst_addu_cnt", instr_cnt, 1);

    apply_reset();
    for (int i = 1; i <= 17; i++) begin
      run_instr(OP_J, 6'd0, 0, -1, 0, el, ls);
      if (i >= 15) begin
        $display("wrap j #%0d instr_cnt4=%0d", i, instr_cnt4);
        check("wrap_cnt4", instr_cnt4, (i == 15) ? 15 : (i == 16) ? 0 : 1);
      end
    end

    for (int i = 0; i < 300; i++) begin
      int k;
      logic [5:0] ro, rf;
      k = $urandom_range(17);
      if (k < 14) begin ro = tbl[k].op; rf = tbl[k].funct; end
      else if (k == 14) begin ro = OP_LW; rf = 6'($urandom); end
      else if (k == 15) begin ro = OP_R; rf = 6'($urandom); end
      else begin ro = 6'($urandom); rf = 6'($urandom); end
      run_instr(ro, rf, 25, -1, 0, el, ls);
      $display("rand %0d op=%b funct=%b elapsed=%0d cnt=%0d", i, ro, rf, el, instr_cnt);
    end
    run_instr(OP_J, 6'd0, 0, -1, 0, el, ls);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
